// File: rtl/tg68k_div_seq.sv
// Multi-cycle signed/unsigned 2W/W restoring divider for the TG68K execution unit.
// Optional macro TG68K_DIV_RADIX4_EN: retire two quotient bits per ITER cycle.
module tg68k_div_seq #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 nReset,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 signed_op,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 overflow,
    output logic                 div_zero
);

`ifdef TG68K_DIV_RADIX4_EN
    localparam logic [CNT_W-1:0] ITERS = CNT_W'(WIDTH / 2);
`else
    localparam logic [CNT_W-1:0] ITERS = CNT_W'(WIDTH);
`endif
    localparam logic [WIDTH-1:0] MIN_MAG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_ITER  = 3'd2,
        S_FIXUP = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t               state_r, state_next_s;
    logic [2*WIDTH-1:0]   rq_r;          // {partial remainder, quotient bits}
    logic [WIDTH-1:0]     dvs_r;
    logic                 signed_r, q_neg_r, r_neg_r;
    logic [CNT_W-1:0]     cnt_r;
    logic                 busy_r, done_r, overflow_r, div_zero_r;
    logic [WIDTH-1:0]     quotient_r, remainder_r;

    logic [2*WIDTH-1:0]   dvd_abs_s, rq_step_s;
    logic [WIDTH-1:0]     dvs_abs_s, q_mag_s, r_mag_s, q_fix_s, r_fix_s;
    logic                 dvd_neg_s, dvs_neg_s, early_ovf_s, fix_ovf_s;

    // One restoring step: shift left, trial subtract, shift in the quotient bit.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] rq,
                                                    input logic [WIDTH-1:0]   d);
        logic [WIDTH:0]   sh;
        logic [WIDTH-1:0] diff;
        sh   = {rq[2*WIDTH-1:WIDTH], rq[WIDTH-1]};
        diff = sh[WIDTH-1:0] - d;
        if (sh >= {1'b0, d}) begin
            return {diff, rq[WIDTH-2:0], 1'b1};
        end else begin
            return {sh[WIDTH-1:0], rq[WIDTH-2:0], 1'b0};
        end
    endfunction

    // Operand conditioning, iteration datapath and sign fix-up.
    always_comb begin
        dvd_neg_s   = signed_op & dividend[2*WIDTH-1];
        dvs_neg_s   = signed_op & divisor[WIDTH-1];
        dvd_abs_s   = dvd_neg_s ? (~dividend + {{(2*WIDTH-1){1'b0}}, 1'b1}) : dividend;
        dvs_abs_s   = dvs_neg_s ? (~divisor + {{(WIDTH-1){1'b0}}, 1'b1}) : divisor;
        early_ovf_s = (rq_r[2*WIDTH-1:WIDTH] >= dvs_r);
`ifdef TG68K_DIV_RADIX4_EN
        rq_step_s   = div_step(div_step(rq_r, dvs_r), dvs_r);
`else
        rq_step_s   = div_step(rq_r, dvs_r);
`endif
        q_mag_s     = rq_r[WIDTH-1:0];
        r_mag_s     = rq_r[2*WIDTH-1:WIDTH];
        q_fix_s     = q_neg_r ? (~q_mag_s + {{(WIDTH-1){1'b0}}, 1'b1}) : q_mag_s;
        r_fix_s     = r_neg_r ? (~r_mag_s + {{(WIDTH-1){1'b0}}, 1'b1}) : r_mag_s;
        // Negative quotients may reach -2^(W-1); positive ones stop one short.
        if (signed_r) begin
            fix_ovf_s = q_neg_r ? (q_mag_s > MIN_MAG) : q_mag_s[WIDTH-1];
        end else begin
            fix_ovf_s = 1'b0;
        end
    end

    // Next-state logic; abort overrides every non-IDLE transition.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start && !abort) state_next_s = S_CHECK;
                else                 state_next_s = S_IDLE;
            end
            S_CHECK: begin
                if (abort)                             state_next_s = S_IDLE;
                else if (dvs_r == '0 || early_ovf_s)   state_next_s = S_DONE;
                else                                   state_next_s = S_ITER;
            end
            S_ITER: begin
                if (abort)                                      state_next_s = S_IDLE;
                else if (cnt_r == {{(CNT_W-1){1'b0}}, 1'b1})    state_next_s = S_FIXUP;
                else                                            state_next_s = S_ITER;
            end
            S_FIXUP: begin
                if (abort) state_next_s = S_IDLE;
                else       state_next_s = S_DONE;
            end
            S_DONE:  state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) state_r <= S_IDLE;
        else         state_r <= state_next_s;
    end

    // Operand latch, iteration registers, results and flags.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            rq_r        <= '0;
            dvs_r       <= '0;
            signed_r    <= 1'b0;
            q_neg_r     <= 1'b0;
            r_neg_r     <= 1'b0;
            cnt_r       <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
            overflow_r  <= 1'b0;
            div_zero_r  <= 1'b0;
        end else begin
            busy_r <= (state_next_s != S_IDLE);
            done_r <= (state_next_s == S_DONE);
            case (state_r)
                S_IDLE: begin
                    if (start && !abort) begin
                        rq_r       <= dvd_abs_s;
                        dvs_r      <= dvs_abs_s;
                        signed_r   <= signed_op;
                        q_neg_r    <= dvd_neg_s ^ dvs_neg_s;
                        r_neg_r    <= dvd_neg_s;
                        overflow_r <= 1'b0;
                        div_zero_r <= 1'b0;
                    end
                end
                S_CHECK: begin
                    if (!abort) begin
                        if (dvs_r == '0)      div_zero_r <= 1'b1;
                        else if (early_ovf_s) overflow_r <= 1'b1;
                        else                  cnt_r      <= ITERS;
                    end
                end
                S_ITER: begin
                    if (!abort) begin
                        rq_r  <= rq_step_s;
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                S_FIXUP: begin
                    if (!abort) begin
                        if (fix_ovf_s) begin
                            overflow_r <= 1'b1;
                        end else begin
                            quotient_r  <= q_fix_s;
                            remainder_r <= r_fix_s;
                        end
                    end
                end
                S_DONE: begin
                    cnt_r <= cnt_r;
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign quotient  = quotient_r;
    assign remainder = remainder_r;
    assign overflow  = overflow_r;
    assign div_zero  = div_zero_r;

endmodule

// File: doc/tg68k_div_seq.md
Name: tg68k_div_seq

Overview:
Parametrised multi-cycle integer divider for the TG68K execution unit; the next generation of the fixed DIVU/DIVS micro-state path (div1..div_end2). It divides a 2*WIDTH-bit dividend by a WIDTH-bit divisor, signed or unsigned, and produces quotient, remainder and exception flags. The decoder issues a start pulse, and the sequencer returns a one-cycle done pulse with registered results.

Parameters:
WIDTH, 32, divisor/quotient/remainder width in bits; even, >= 4
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden)

Ports:
clk  in  1  system clock; all state changes on rising edge
nReset  in  1  asynchronous active-low reset
start  in  1  begin division; sampled only in IDLE
abort  in  1  synchronous cancel; returns to IDLE with no done pulse
signed_op  in  1  1 = DIVS semantics, 0 = DIVU; sampled with start
dividend  in  2*WIDTH  dividend; sampled with start
divisor  in  WIDTH  divisor; sampled with start
busy  out  1  state != IDLE
done  out  1  one-cycle pulse, results valid
quotient  out  WIDTH  registered quotient
remainder  out  WIDTH  registered remainder
overflow  out  1  quotient not representable; valid with done
div_zero  out  1  divisor was zero; valid with done

Behaviour:
- Reset (async, nReset=0): state=IDLE, busy=0, done=0, quotient=0, remainder=0, overflow=0, div_zero=0, counter=0. Reset mid-operation discards all work.
- States: IDLE, CHECK, ITER, FIXUP, DONE.
- IDLE: on start=1, latch the operands and signed_op, then go to CHECK. In signed mode, form absolute values and record the result signs: quotient sign = dividend sign XOR divisor sign; remainder sign = dividend sign.
- CHECK: if divisor==0, set div_zero=1 and go to DONE. Otherwise, if the upper WIDTH bits of the absolute dividend >= the absolute divisor, set overflow=1 and go to DONE (early out). Otherwise load counter=WIDTH and go to ITER.
- ITER: one restoring step per cycle (shift the partial remainder left 1 bit, trial subtract, set the quotient bit), decrement the counter, and go to FIXUP when the counter reaches 0.
- FIXUP: apply the signs (two's-complement negate). Signed overflow occurs if the positive quotient magnitude > 2^(WIDTH-1)-1 or the negative quotient magnitude > 2^(WIDTH-1). Then go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE. quotient and remainder update only on a clean result. On overflow or div_zero they hold their previous values, matching the 68k rule that the destination is unchanged.
- Latency: done is high in the cycle after the edge that is WIDTH+3 edges from the sampling edge of start. This is WIDTH+2 cycles in busy before DONE; 35 edges total for WIDTH=32. Early exits (div_zero, unsigned/early overflow) take 2 edges.
- Flags: overflow and div_zero are cleared when start is accepted and hold until the next accepted start.
- Arithmetic: quotient truncates toward zero; remainder has the dividend's sign; |remainder| < |divisor|.
- start while busy: ignored, with no effect on the operation in flight.
- abort: highest priority after reset, effective in any non-IDLE state. Next state is IDLE, no done pulse, results and flags unchanged. start and abort together in IDLE: abort wins and start is dropped.
- Start in the DONE cycle is ignored; start is accepted from the following IDLE cycle.

Optional Feature:
TG68K_DIV_RADIX4_EN
- Defined: ITER retires 2 quotient bits per cycle using two cascaded trial subtractions. Counter loads WIDTH/2. Latency is WIDTH/2+3 edges (19 for WIDTH=32). Results and flags are bit-identical to radix-2.
- Undefined: radix-2, one bit per cycle as above.

Test Plan:
1. Unsigned, WIDTH=32: 100 / 7 -> quotient=14, remainder=2, flags 0; done exactly 35 edges after start (19 with TG68K_DIV_RADIX4_EN).
2. Signed: dividend=-7 (0xFFFFFFFF_FFFFFFF9) / 2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Also 7 / -2 -> quotient=0xFFFFFFFD, remainder=1.
3. Divisor=0 with prior quotient=0x12345678 -> div_zero=1 and done after 2 edges; quotient/remainder unchanged; busy low the next cycle.
4. Overflow:
   - Unsigned 0x00000001_00000000 / 1 -> overflow=1 at 2 edges.
   - Signed 0x00000000_80000000 / 1 -> overflow=1 at 35 edges.
   - Signed 0xFFFFFFFF_80000000 / 1 -> quotient=0x80000000, overflow=0.
5. start pulsed again at edge 10 of an operation -> ignored, first result correct. abort at edge 20 -> busy=0 next cycle, no done, outputs unchanged.
6. nReset low at edge 15 mid-ITER -> all outputs 0 immediately (async). A new 1000/10 after release -> quotient=100, remainder=0.
